// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the unified memory arbiter
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } arb_gnt_e;

   localparam int STARVE_MAX_DEF = 4;
   localparam int TIMEOUT_DEF    = 15;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts WAIT cycles and flags the last cycle before giving up
module mem_timeout_ctr
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // expired marks the TIMEOUT-th enabled cycle, so the owner leaves on that edge
   assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CW'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/unified_mem_arb.sv
// rtl/unified_mem_arb.sv - arbitrates fetch and data ports onto one single-port memory
module unified_mem_arb
   import mips_mem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_e    state_q, state_d;
   arb_gnt_e      gnt_q, gnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;
   logic          err_q, err_d;
   logic          fetch_win;
   logic          tmr_clr;
   logic          tmr_en;
   logic          tmr_expired;

   assign tmr_en  = (state_q == WAIT);
   assign tmr_clr = (state_q != WAIT);

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      err_d      = err_q;
      fetch_win  = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               // data wins by default; a starved fetch gets one turn
               fetch_win = if_req && (!dm_req || (starve_q == SW'(STARVE_MAX)));
               state_d   = WAIT;
               if (fetch_win) begin
                  gnt_d    = GNT_IF;
                  addr_d   = if_addr;
                  we_d     = 1'b0;
                  wdata_d  = '0;
                  starve_d = '0;
               end else begin
                  gnt_d   = GNT_DM;
                  addr_d  = dm_addr;
                  we_d    = dm_we;
                  wdata_d = dm_wdata;
                  if (if_req && (starve_q != SW'(STARVE_MAX))) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end

         WAIT: begin
            // an ack in the expiry cycle still counts as a normal completion
            if (mem_ack) begin
               state_d = DONE;
               if (gnt_q == GNT_IF) begin
                  if_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  dm_rdata_d = mem_rdata;
               end
            end else if (tmr_expired) begin
               state_d = DONE;
               err_d   = 1'b1;
               if (gnt_q == GNT_IF) begin
                  if_rdata_d = '0;
               end else if (!we_q) begin
                  dm_rdata_d = '0;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         err_q      <= err_d;
      end
   end

   assign mem_req   = (state_q == WAIT);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign if_valid  = (state_q == DONE) && (gnt_q == GNT_IF);
   assign dm_valid  = (state_q == DONE) && (gnt_q == GNT_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign err       = err_q;

   assign stall_if  = if_req && !if_valid;
   assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_unified_mem_arb.sv
// tb/tb_unified_mem_arb.sv - randomized self-checking bench with a transaction-level model
module tb_unified_mem_arb;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 15;
   localparam int NEVER      = 99;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem, err;

   int checks   = 0;
   int failures = 0;

   int          starve_m;
   bit          err_m;
   logic [31:0] exp_if_rd, exp_dm_rd;
   logic [31:0] mem_m [bit [31:0]];
   int          grants[$];

   unified_mem_arb #(
      .STARVE_MAX (STARVE_MAX),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      starve_m  = 0;
      err_m     = 1'b0;
      exp_if_rd = '0;
      exp_dm_rd = '0;
   endtask

   task automatic refill(input bit force_both);
      if (!if_req && (force_both || ($urandom_range(0, 9) < 6))) begin
         if_req  = 1'b1;
         if_addr = 32'($urandom_range(0, 15));
      end
      if (!dm_req && (force_both || ($urandom_range(0, 9) < 6))) begin
         dm_req   = 1'b1;
         dm_we    = 1'($urandom_range(0, 1));
         dm_addr  = 32'($urandom_range(0, 15));
         dm_wdata = $urandom;
      end
      if (!if_req && !dm_req) begin
         dm_req  = 1'b1;
         dm_we   = 1'b0;
         dm_addr = 32'($urandom_range(0, 15));
      end
   endtask

   // Called at the falling edge of an idle cycle with at least one request up;
   // returns at the falling edge of the idle cycle that follows completion.
   task automatic do_access(input int ack_at);
      bit          win_if;
      bit          acked;
      logic        we;
      logic [31:0] a, wd, rdv;

      win_if = if_req && (!dm_req || (starve_m == STARVE_MAX));
      if (win_if) begin
         a        = if_addr;
         we       = 1'b0;
         wd       = '0;
         starve_m = 0;
      end else begin
         a  = dm_addr;
         we = dm_we;
         wd = dm_wdata;
         if (if_req && (starve_m < STARVE_MAX)) starve_m++;
      end
      rdv = mem_m.exists(a) ? mem_m[a] : $urandom;

      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_valid", 32'({if_valid, dm_valid}), 32'd0);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      acked     = 1'b0;

      @(negedge clk);
      for (int j = 1; j <= TIMEOUT; j++) begin
         chk("wait_mem_req", 32'(mem_req), 32'd1);
         chk("wait_addr", mem_addr, a);
         chk("wait_we", 32'(mem_we), 32'(we));
         if (we) chk("wait_wdata", mem_wdata, wd);
         chk("wait_valid", 32'({if_valid, dm_valid}), 32'd0);
         chk("wait_stall", 32'({stall_if, stall_mem}), 32'({if_req, dm_req}));
         mem_ack   = (j == ack_at);
         mem_rdata = (j == ack_at) ? rdv : $urandom;
         if (j == ack_at) acked = 1'b1;
         if ((j == ack_at) || (j == TIMEOUT)) break;
         @(negedge clk);
      end
      @(negedge clk);

      if (acked) begin
         if (win_if)   exp_if_rd = rdv;
         else if (!we) exp_dm_rd = rdv;
         else          mem_m[a]  = wd;
      end else begin
         err_m = 1'b1;
         if (win_if)   exp_if_rd = '0;
         else if (!we) exp_dm_rd = '0;
      end

      mem_ack = 1'($urandom_range(0, 1));
      chk("done_valid", 32'({if_valid, dm_valid}), 32'({win_if, !win_if}));
      chk("done_if_rdata", if_rdata, exp_if_rd);
      chk("done_dm_rdata", dm_rdata, exp_dm_rd);
      chk("done_err", 32'(err), 32'(err_m));
      chk("done_mem_req", 32'(mem_req), 32'd0);
      chk("done_stall", 32'({stall_if, stall_mem}),
          32'({if_req && !win_if, dm_req && win_if}));
      grants.push_back(int'(win_if));
      if (win_if) if_req = 1'b0;
      else        dm_req = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   initial begin
      int exp_order[6];
      int ack_at;
      int r;

      exp_order = '{0, 0, 0, 0, 1, 0};
      rst       = 1'b0;
      if_req    = 1'b0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      if_addr   = '0;
      dm_addr   = '0;
      dm_wdata  = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_valid", 32'({if_valid, dm_valid}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      mem_m[32'h10] = 32'h8C220004;
      if_req  = 1'b1;
      if_addr = 32'h10;
      #0;
      chk("fetch_stall_c0", 32'(stall_if), 32'd1);
      do_access(2);
      chk("fetch_rdata", if_rdata, 32'h8C220004);

      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h20;
      dm_wdata = 32'hCAFEF00D;
      do_access(3);
      chk("store_dm_rdata_kept", dm_rdata, 32'd0);
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h20;
      do_access(1);
      chk("load_back", dm_rdata, 32'hCAFEF00D);

      grants.delete();
      for (int i = 0; i < 6; i++) begin
         refill(1'b1);
         do_access(1);
      end
      for (int i = 0; i < 6; i++) chk("starve_order", 32'(grants[i]), 32'(exp_order[i]));

      dm_req = 1'b0;
      if (!if_req) begin
         if_req  = 1'b1;
         if_addr = 32'h4;
      end
      do_access(NEVER);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_if_rdata", if_rdata, 32'd0);
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h20;
      do_access(TIMEOUT);
      chk("tie_dm_rdata", dm_rdata, 32'hCAFEF00D);
      chk("tie_err_sticky", 32'(err), 32'd1);

      if_req  = 1'b0;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h5;
      @(negedge clk);
      chk("abort_in_wait", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_valid", 32'({if_valid, dm_valid}), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      chk("abort_rdata", {if_rdata[15:0], dm_rdata[15:0]}, 32'd0);
      model_reset();
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_valid", 32'({if_valid, dm_valid}), 32'd0);
      end
      rst     = 1'b1;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h20;
      do_access(2);
      chk("resume_dm_rdata", dm_rdata, 32'hCAFEF00D);

      for (int n = 0; n < 250; n++) begin
         refill(1'b0);
         r = int'($urandom_range(0, 19));
         if (r < 15)      ack_at = (r % 4) + 1;
         else if (r < 18) ack_at = TIMEOUT;
         else             ack_at = NEVER;
         do_access(ack_at);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unified_mem_arb.md
UNIFIED_MEM_ARB -- requirements
Module: unified_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles allowed without mem_ack.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request; held high until if_valid.
REQ-006 if_addr  in  32  fetch word address (PC).
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_valid  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req  in  1  data request; held high until dm_valid.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  32  data word address (ALU result).
REQ-012 dm_wdata  in  32  store data.
REQ-013 dm_rdata  out  32  load data.
REQ-014 dm_valid  out  1  one-cycle data completion pulse.
REQ-015 mem_req  out  1  request to the single-port unified memory.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  32  memory word address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data; valid in the mem_ack cycle.
REQ-020 mem_ack  in  1  memory completion strobe.
REQ-021 stall_if  out  1  equals if_req AND NOT if_valid.
REQ-022 stall_mem  out  1  equals dm_req AND NOT dm_valid.
REQ-023 err  out  1  sticky timeout flag.

Function
REQ-024 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-025 In IDLE, if any request is high, the arbiter SHALL latch the winner, its address, dm_we and dm_wdata, and go to WAIT.
REQ-026 Arbitration SHALL favour dm_req over if_req, except that if_req wins when starve_cnt equals STARVE_MAX.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant made while if_req is high, and SHALL clear on each fetch grant.
REQ-028 In WAIT, mem_req SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL come from latched values and stay stable until exit.
REQ-029 For a fetch grant, mem_we SHALL be 0.
REQ-030 On mem_ack in WAIT, the arbiter SHALL capture mem_rdata into the granted port's rdata register (loads and fetches only) and go to DONE.
REQ-031 For a store, dm_rdata SHALL remain unchanged.
REQ-032 In DONE, the granted port's valid SHALL be 1 for exactly that cycle; requests SHALL be ignored and the next state SHALL be IDLE.
REQ-033 Latency: request sampled in IDLE at cycle 0, mem_req high from cycle 1, mem_ack at cycle k, valid at cycle k+1.
REQ-034 Throughput SHALL be at most one access per (k+1) cycles.
REQ-035 A WAIT-cycle counter SHALL clear on entry to WAIT.
REQ-036 If the WAIT-cycle counter reaches TIMEOUT without mem_ack, the arbiter SHALL set err, go to DONE, load 32'h0 into the granted rdata, and pulse valid.
REQ-037 err SHALL remain set until reset.
REQ-038 mem_ack SHALL be ignored in IDLE and DONE.
REQ-039 mem_ack arriving in the same cycle as the timeout SHALL win: no error, and data is captured.
REQ-040 if_rdata and dm_rdata SHALL hold their values between completions.

Reset
REQ-041 Asserting rst (low) SHALL immediately force state IDLE, mem_req=0, mem_we=0, if_valid=0, dm_valid=0, err=0, starve_cnt=0, timeout counter=0, if_rdata=0 and dm_rdata=0.
REQ-042 A reset during WAIT SHALL abort the access without producing a valid pulse.
REQ-043 Operation SHALL resume from the first clock edge after rst deasserts.

Structure
REQ-044 Package mips_mem_pkg SHALL hold the state enum (IDLE/WAIT/DONE), the grant encoding (GNT_IF/GNT_DM) and the default STARVE_MAX/TIMEOUT constants.
REQ-045 The timeout counter SHALL be the sub-module mem_timeout_ctr (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-046 Single fetch, if_addr=0x10, mem_ack 2 cycles after mem_req, mem_rdata=0x8C220004 -> if_valid at cycle 3, if_rdata=0x8C220004, stall_if high in cycles 0-2.
REQ-047 Store, dm_addr=0x20, dm_wdata=0xCAFEF00D -> mem_we=1 and mem_addr=0x20 held until ack; dm_valid pulses; dm_rdata unchanged.
REQ-048 if_req and dm_req both held continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM…
REQ-049 mem_ack never asserted, TIMEOUT=15 -> err=1 after 15 WAIT cycles; valid pulses with rdata=0; err stays 1 across later accesses.
REQ-050 rst driven low mid-WAIT -> mem_req=0 with no clock edge; no valid pulse; after release, a fresh request completes normally.
REQ-051 Spurious mem_ack in IDLE plus back-to-back loads -> no spurious valid; each dm_valid is separated by at least one IDLE cycle.
